// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: core-side fetch and load/store request bundle for mem_ctrl
//   master (core): i_waiting, i_addr, d_waiting, d_wr, d_len, d_addr, d_value out;
//                  i_result, i_rdy, mem_result, mem_rdy in
//   slave (mem_ctrl): the mirror image
interface mem_ctrl_if;
  logic        i_waiting;
  logic [31:0] i_addr;
  logic [31:0] i_result;
  logic        i_rdy;
  logic        d_waiting;
  logic        d_wr;
  logic [2:0]  d_len;
  logic [31:0] d_addr;
  logic [31:0] d_value;
  logic [31:0] mem_result;
  logic        mem_rdy;
  modport master (
    output i_waiting, i_addr, d_waiting, d_wr, d_len, d_addr, d_value,
    input  i_result, i_rdy, mem_result, mem_rdy
  );
  modport slave (
    input  i_waiting, i_addr, d_waiting, d_wr, d_len, d_addr, d_value,
    output i_result, i_rdy, mem_result, mem_rdy
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises fetch and load/store requests onto a byte-wide RAM/IO port
//   clk_in, rst_in (async, active low), rdy_in (global freeze), RoB_clear (flush)
//   bus            : mem_ctrl_if.slave, core-side requests and completions
//   mem_din/mem_dout/mem_a/mem_wr : byte RAM/IO port, read data one cycle late
//   io_buffer_full : IO write back-pressure, honoured only with MEMCTRL_IO_STALL_EN
module mem_ctrl #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        RoB_clear,
  mem_ctrl_if.slave   bus,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);
  localparam logic [2:0] IDLE = 3'd0, IFETCH = 3'd1, LOAD = 3'd2, STORE = 3'd3, DONE = 3'd4;
  logic [2:0]  state, step, n;
  logic [31:0] base, asm_q;
  logic        own_d, sgn, busy, stall;
  logic [1:0]  cap;
  assign busy = state == IFETCH || state == LOAD || state == STORE;
  // read data lags its address by one cycle, so the byte landing now belongs to step-1
  assign cap = step[1:0] - 2'd1;
`ifdef MEMCTRL_IO_STALL_EN
  assign stall = state == STORE && base[17:16] == IO_SEL && io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_buffer_full ^ (^IO_SEL);
  assign stall = 1'b0;
`endif
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state <= IDLE;
      step  <= 3'd0;
      n     <= 3'd0;
      base  <= 32'd0;
      asm_q <= 32'd0;
      own_d <= 1'b0;
      sgn   <= 1'b0;
    end else if (rdy_in) begin
      case (state)
        IDLE:
          if (bus.d_waiting) begin
            state <= bus.d_wr ? STORE : LOAD;
            own_d <= 1'b1;
            base  <= bus.d_addr;
            n     <= bus.d_len[1:0] == 2'd0 ? 3'd1 : bus.d_len[1:0] == 2'd1 ? 3'd2 : 3'd4;
            sgn   <= bus.d_len[2];
            asm_q <= bus.d_wr ? bus.d_value : 32'd0;
            step  <= 3'd0;
          end else if (bus.i_waiting) begin
            state <= IFETCH;
            own_d <= 1'b0;
            base  <= bus.i_addr;
            n     <= 3'd4;
            sgn   <= 1'b0;
            asm_q <= 32'd0;
            step  <= 3'd0;
          end
        IFETCH, LOAD:
          if (RoB_clear) state <= IDLE;
          else begin
            if (step != 3'd0) asm_q[{cap, 3'b000} +: 8] <= mem_din;
            step <= step + 3'd1;
            if (step == n) state <= DONE;
          end
        STORE:
          if (!stall) begin
            step <= step + 3'd1;
            if (step == n - 3'd1) state <= DONE;
          end
        default: state <= IDLE;
      endcase
    end
  assign mem_a    = busy ? base + {29'd0, step} : 32'd0;
  assign mem_dout = state == STORE ? asm_q[{step[1:0], 3'b000} +: 8] : 8'h00;
  assign mem_wr   = rdy_in && state == STORE && !stall;
  // pulses are gated by rdy_in so a frozen DONE cycle still yields a single completion
  assign bus.i_rdy      = rdy_in && state == DONE && !own_d;
  assign bus.mem_rdy    = rdy_in && state == DONE && own_d;
  assign bus.i_result   = asm_q;
  assign bus.mem_result = n == 3'd1 ? {{24{sgn & asm_q[7]}}, asm_q[7:0]} :
                          n == 3'd2 ? {{16{sgn & asm_q[15]}}, asm_q[15:0]} : asm_q;
endmodule
